target_resolve_queue: RTL and testbench

Resolution-side companion of the indirect-branch target predictor. Fetch pushes one entry per predicted indirect branch (cache index, predicted target). When EX resolves the oldest branch, this block pops the entry, compares targets, and on a mismatch issues the target-cache write (`PC_check`, `index_update`, `PC_update`) and a redirect/flush pulse. It owns the in-flight ordering between the prediction and update ends of the target cache.

---
 rtl/target_resolve_queue.sv | 134 +++++++++++++
 tb/tb_target_resolve_queue.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/target_resolve_queue.sv
// target_resolve_queue
//
// Resolution-side companion of the indirect-branch target predictor. Fetch
// pushes {cache index, predicted target} for every predicted indirect branch;
// when EX resolves the oldest branch the head entry is popped and its target
// compared with the actual one. A mismatch produces, one cycle later, a
// target-cache write (PC_check_o / index_update_o / PC_update_o) and a
// one-cycle redirect pulse (mispredict_o / redirect_pc_o). All younger
// entries are flushed and the block spends one cycle in RECOVER.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   stall                             front-end stall, blocks push only
//   push_i, push_index_i, push_target_i   new prediction from fetch
//   full_o, empty_o, count_o          occupancy (from registered state)
//   resolve_i, actual_target_i        EX resolution of the oldest branch
//   PC_check_o, index_update_o, PC_update_o   target-cache write port
//   mispredict_o, redirect_pc_o       flush/redirect pulse and target
//   err_underflow_o                   sticky: resolve seen while empty
module target_resolve_queue #(
    parameter int DEPTH = 4,
    parameter int width = 10,
    parameter int ptr_w = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             push_i,
    input  logic [width-1:0] push_index_i,
    input  logic [31:0]      push_target_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [ptr_w:0]   count_o,
    input  logic             resolve_i,
    input  logic [31:0]      actual_target_i,
    output logic             PC_check_o,
    output logic [width-1:0] index_update_o,
    output logic [31:0]      PC_update_o,
    output logic             mispredict_o,
    output logic [31:0]      redirect_pc_o,
    output logic             err_underflow_o
);

    typedef enum logic {RUN, RECOVER} state_t;

    state_t           state_reg, state_next;
    logic [ptr_w-1:0] rd_ptr_reg, rd_ptr_next;
    logic [ptr_w-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ptr_w:0]   count_reg, count_next;

    logic [width-1:0] idx_mem [DEPTH];
    logic [31:0]      tgt_mem [DEPTH];

    logic             push_acc;
    logic             pop_ok;
    logic             mismatch;
    logic             bad_resolve;

    assign full_o  = (count_reg == (ptr_w+1)'(DEPTH)) || (state_reg == RECOVER);
    assign empty_o = (count_reg == '0);
    assign count_o = count_reg;

    // Entry storage: one register pair per slot, written only on an accepted push.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (push_acc && (wr_ptr_reg == ptr_w'(gi))) begin
                    idx_mem[gi] <= push_index_i;
                    tgt_mem[gi] <= push_target_i;
                end
            end
        end
    endgenerate

    always_comb begin
        pop_ok      = 1'b0;
        mismatch    = 1'b0;
        push_acc    = 1'b0;
        bad_resolve = 1'b0;
        state_next  = RUN;          // RECOVER always lasts exactly one cycle
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;

        // In RECOVER the queue is empty by construction, so a resolve there is
        // the same error as a resolve while empty.
        pop_ok      = resolve_i && !empty_o && (state_reg == RUN);
        bad_resolve = resolve_i && !pop_ok;
        mismatch    = pop_ok && (actual_target_i != tgt_mem[rd_ptr_reg]);
        // A push alongside a mispredicting resolve is on the wrong path.
        push_acc    = push_i && !stall && !full_o && !mismatch;

        if (mismatch) begin
            state_next  = RECOVER;
            rd_ptr_next = rd_ptr_reg + 1'b1;
            wr_ptr_next = rd_ptr_reg + 1'b1;
            count_next  = '0;
        end else begin
            rd_ptr_next = rd_ptr_reg + ptr_w'(pop_ok);
            wr_ptr_next = wr_ptr_reg + ptr_w'(push_acc);
            count_next  = count_reg + (ptr_w+1)'(push_acc) - (ptr_w+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= RUN;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            count_reg       <= '0;
            PC_check_o      <= 1'b0;
            mispredict_o    <= 1'b0;
            index_update_o  <= '0;
            PC_update_o     <= '0;
            redirect_pc_o   <= '0;
            err_underflow_o <= 1'b0;
        end else begin
            state_reg       <= state_next;
            rd_ptr_reg      <= rd_ptr_next;
            wr_ptr_reg      <= wr_ptr_next;
            count_reg       <= count_next;
            PC_check_o      <= mismatch;
            mispredict_o    <= mismatch;
            err_underflow_o <= err_underflow_o | bad_resolve;
            // Write/redirect payload is only meaningful with the pulse; hold otherwise.
            if (mismatch) begin
                index_update_o <= idx_mem[rd_ptr_reg];
                PC_update_o    <= actual_target_i;
                redirect_pc_o  <= actual_target_i;
            end
        end
    end

endmodule

// File: tb/tb_target_resolve_queue.sv
module tb_target_resolve_queue;

    localparam int DEPTH = 4;
    localparam int W     = 10;
    localparam int PW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic          push_i;
    logic [W-1:0]  push_index_i;
    logic [31:0]   push_target_i;
    logic          full_o, empty_o;
    logic [PW:0]   count_o;
    logic          resolve_i;
    logic [31:0]   actual_target_i;
    logic          PC_check_o;
    logic [W-1:0]  index_update_o;
    logic [31:0]   PC_update_o;
    logic          mispredict_o;
    logic [31:0]   redirect_pc_o;
    logic          err_underflow_o;

    target_resolve_queue #(.DEPTH(DEPTH), .width(W), .ptr_w(PW)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .push_i(push_i), .push_index_i(push_index_i), .push_target_i(push_target_i),
        .full_o(full_o), .empty_o(empty_o), .count_o(count_o),
        .resolve_i(resolve_i), .actual_target_i(actual_target_i),
        .PC_check_o(PC_check_o), .index_update_o(index_update_o),
        .PC_update_o(PC_update_o), .mispredict_o(mispredict_o),
        .redirect_pc_o(redirect_pc_o), .err_underflow_o(err_underflow_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [W-1:0] idx;
        logic [31:0]  tgt;
    } ent_t;

    ent_t         m_q[$];
    bit           m_rec;
    bit           m_mis;
    bit           m_err;
    logic [W-1:0] m_idx;
    logic [31:0]  m_upd;
    bit           check_en = 0;

    always @(posedge clk) begin
        bit   m_full, m_empty, popped_bad;
        ent_t h;
        if (rst) begin
            m_q.delete();
            m_rec = 0; m_mis = 0; m_err = 0; m_idx = '0; m_upd = '0;
        end else begin
            m_full     = (m_q.size() == DEPTH) || m_rec;
            m_empty    = (m_q.size() == 0);
            popped_bad = 0;
            m_mis      = 0;
            if (resolve_i) begin
                if (m_empty || m_rec) m_err = 1;
                else begin
                    h = m_q.pop_front();
                    if (h.tgt != actual_target_i) begin
                        popped_bad = 1;
                        m_mis = 1; m_idx = h.idx; m_upd = actual_target_i;
                        m_q.delete();
                    end
                end
            end
            if (push_i && !stall && !m_full && !popped_bad)
                m_q.push_back('{idx: push_index_i, tgt: push_target_i});
            m_rec = popped_bad;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("count",      32'(count_o),        32'(m_q.size()));
            chk("empty",      32'(empty_o),        32'(m_q.size() == 0));
            chk("full",       32'(full_o),         32'((m_q.size() == DEPTH) || m_rec));
            chk("pc_check",   32'(PC_check_o),     32'(m_mis));
            chk("mispredict", 32'(mispredict_o),   32'(m_mis));
            chk("index_upd",  32'(index_update_o), 32'(m_idx));
            chk("pc_update",  PC_update_o,         m_upd);
            chk("redirect",   redirect_pc_o,       m_upd);
            chk("err_uf",     32'(err_underflow_o), 32'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        push_i = 0; resolve_i = 0; stall = 0; rst = 0;
    endtask

    task automatic do_push(input logic [W-1:0] idx, input logic [31:0] tgt);
        push_i = 1; push_index_i = idx; push_target_i = tgt;
    endtask

    task automatic do_resolve(input logic [31:0] act);
        resolve_i = 1; actual_target_i = act;
    endtask

    initial begin
        rst = 1; stall = 0; push_i = 0; resolve_i = 0;
        push_index_i = '0; push_target_i = '0; actual_target_i = '0;
        tick; tick;
        check_en = 1;
        $display("txn reset");
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_empty", 32'(empty_o), 32'd1);
        chk("rst_full",  32'(full_o),  32'd0);
        chk("rst_mis",   32'(mispredict_o), 32'd0);

        // Matching resolve
        idle; do_push(10'h3A, 32'h0000_1000); tick;
        $display("txn push idx=3a tgt=00001000");
        chk("t1_count1", 32'(count_o), 32'd1);
        idle; do_resolve(32'h0000_1000); tick;
        $display("txn resolve match 00001000");
        chk("t1_count0", 32'(count_o), 32'd0);
        chk("t1_empty",  32'(empty_o), 32'd1);
        chk("t1_nomis",  32'(mispredict_o), 32'd0);

        // Mispredict
        idle; do_push(10'h05, 32'h0000_2000); tick;
        $display("txn push idx=05 tgt=00002000");
        idle; do_resolve(32'h0000_2040); tick;
        $display("txn resolve mismatch 00002040");
        chk("t2_pccheck", 32'(PC_check_o),     32'd1);
        chk("t2_index",   32'(index_update_o), 32'h05);
        chk("t2_update",  PC_update_o,         32'h0000_2040);
        chk("t2_mis",     32'(mispredict_o),   32'd1);
        chk("t2_redir",   redirect_pc_o,       32'h0000_2040);
        chk("t2_full_rec", 32'(full_o),        32'd1);
        idle; tick;
        chk("t2_mis_off", 32'(mispredict_o), 32'd0);
        chk("t2_full_off", 32'(full_o), 32'd0);

        // Fill, overflow, pop with simultaneous push
        for (int k = 1; k <= 5; k++) begin
            idle; do_push(W'(k), 32'h100 * k); tick;
            $display("txn push idx=%0d tgt=%h count=%0d", k, 32'h100 * k, count_o);
        end
        chk("t3_count4", 32'(count_o), 32'd4);
        chk("t3_full",   32'(full_o),  32'd1);
        idle; do_resolve(32'h100); do_push(10'h6, 32'h600); tick;   // push rejected: full
        $display("txn resolve+push at full count=%0d", count_o);
        chk("t3_count3", 32'(count_o), 32'd3);
        idle; do_resolve(32'h200); do_push(10'h7, 32'h700); tick;   // both happen
        $display("txn resolve+push count=%0d", count_o);
        chk("t3_count3b", 32'(count_o), 32'd3);
        foreach (m_q[i]) ; // no-op: model state is checked by the compare process
        for (int k = 0; k < 3; k++) begin
            idle;
            case (k)
                0: do_resolve(32'h300);
                1: do_resolve(32'h400);
                default: do_resolve(32'h700);
            endcase
            tick;
            $display("txn resolve match #%0d count=%0d", k, count_o);
        end
        chk("t3_empty", 32'(empty_o), 32'd1);

        // Flush with same-cycle push, push in RECOVER ignored
        for (int k = 0; k < 3; k++) begin
            idle; do_push(W'(10'h20 + k), 32'h8000 + k); tick;
        end
        idle; do_resolve(32'hDEAD_0000); do_push(10'h2F, 32'h9999); tick;
        $display("txn flush resolve count=%0d mis=%0b", count_o, mispredict_o);
        chk("t4_count0", 32'(count_o), 32'd0);
        chk("t4_index",  32'(index_update_o), 32'h20);
        idle; do_push(10'h30, 32'hAAAA); tick;
        $display("txn push in recover count=%0d", count_o);
        chk("t4_rec_drop", 32'(count_o), 32'd0);
        idle; tick;

        // Underflow and stall
        idle; do_resolve(32'h1234); tick;
        $display("txn resolve empty err=%0b", err_underflow_o);
        chk("t5_err", 32'(err_underflow_o), 32'd1);
        idle; stall = 1; do_push(10'h11, 32'h1111); tick;
        $display("txn stalled push count=%0d", count_o);
        chk("t5_stall", 32'(count_o), 32'd0);
        idle; tick; tick;
        chk("t5_err_sticky", 32'(err_underflow_o), 32'd1);

        // Reset right after a mispredicting resolve
        idle; do_push(10'h12, 32'h1200); tick;
        idle; do_resolve(32'h1204); tick;
        $display("txn mismatch then rst mis=%0b", mispredict_o);
        idle; rst = 1; tick;
        $display("txn rst count=%0d mis=%0b", count_o, mispredict_o);
        chk("t6_mis",   32'(mispredict_o), 32'd0);
        chk("t6_count", 32'(count_o), 32'd0);
        chk("t6_full",  32'(full_o), 32'd0);
        chk("t6_err",   32'(err_underflow_o), 32'd0);

        // Reset coincident with a mismatching resolve
        idle; do_push(10'h13, 32'h1300); tick;
        idle; do_resolve(32'h1304); rst = 1; tick;
        $display("txn rst with resolve mis=%0b", mispredict_o);
        chk("t7_mis",   32'(mispredict_o), 32'd0);
        chk("t7_count", 32'(count_o), 32'd0);
        idle; tick; tick;
        chk("t7_idle_mis", 32'(mispredict_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
